dac_spi_tx: RTL

- Downstream stage of the DDS core. Consumes the 8-bit waveform sample and serialises it to an external SPI DAC, one 16-bit frame per sample period.
- Owns the output sample rate. It captures the DDS sample on a programmable sample tick and drives chip-select, serial clock and data to the DAC pins.

---
 rtl/dac_spi_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//
// Serialises the 8-bit DDS waveform sample to an external SPI DAC, one 16-bit
// frame per sample period. A free-running sample timer sets the output rate.
// On each timer tick the current sample is captured (when enabled) and shifted
// out MSB first as {CTRL_BITS, sample, 4'b0000}.
//
// A frame lasts 34*CLK_DIV cycles and goes through these phases:
//   SETUP    (1 half-period)   cs_n low, first bit on din
//   SHIFT_HI (16 half-periods) sclk high, the DAC samples din
//   SHIFT_LO (16 half-periods) sclk low, the next bit is presented
//   HOLD     (1 half-period)   cs_n high before returning to IDLE
//
// Parameters:
//   CLK_DIV     sys_clk cycles per dac_sclk half-period (1..255)
//   SAMPLE_DIV  sys_clk cycles per sample tick (>= 34*CLK_DIV+1 to avoid overrun)
//   CTRL_BITS   DAC command nibble, sent in frame bits [15:12]
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   enable     in   1 = start a frame on each sample tick
//   data_in    in   [7:0] DDS sample, captured only at a tick
//   dac_cs_n   out  DAC chip select, active low
//   dac_sclk   out  DAC serial clock, idles low
//   dac_din    out  DAC serial data, MSB first
//   busy       out  high from frame capture until return to IDLE
//   overrun    out  one-cycle pulse when an enabled tick is dropped while busy
// -----------------------------------------------------------------------------
module dac_spi_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 100,
  parameter logic [3:0]  CTRL_BITS  = 4'b0000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned       TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] SHIFT_LO = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [7:0]        div_cnt;
  logic              phase_end;
  logic [4:0]        bit_cnt;
  logic [15:0]       shift_reg;
  logic [2:0]        state;

  assign tick      = (tick_cnt == TICK_LAST);
  assign phase_end = (div_cnt == DIV_LAST);

  // Sample timer: free-running, independent of enable and of the frame FSM.
  // NOTE: every register here uses non-blocking assignments so that all state
  // updates on a clock edge see the pre-edge values; blocking assignments in
  // clocked blocks create order-dependent simulation/synthesis mismatches.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame FSM. Outputs are set on the transition into each state, so every
  // pin comes straight from a flop and cannot glitch.
  // NOTE: the shift register and counters are ordinary flops, not a memory,
  // so they are cleared by the async reset along with the pins; this keeps a
  // frame aborted by reset from leaking stale bits into the next one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      dac_cs_n  <= 1'b1;
      dac_sclk  <= 1'b0;
      dac_din   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A tick that arrives while a frame is in flight is dropped, never queued.
      overrun <= tick && enable && (state != IDLE);

      // Every state change happens on phase_end, so wrapping here also gives
      // a fresh half-period count on each state entry.
      div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;

      case (state)
        IDLE: begin
          div_cnt <= 8'd0;
          if (tick && enable) begin
            state     <= SETUP;
            shift_reg <= {CTRL_BITS, data_in, 4'b0000};
            bit_cnt   <= 5'd0;
            busy      <= 1'b1;
            dac_cs_n  <= 1'b0;
            dac_sclk  <= 1'b0;
            dac_din   <= CTRL_BITS[3];
          end
        end

        SETUP: begin
          if (phase_end) begin
            state    <= SHIFT_HI;
            dac_sclk <= 1'b1;
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            // Falling edge: advance to the next bit so din settles a full
            // half-period before the next rising edge.
            state     <= SHIFT_LO;
            dac_sclk  <= 1'b0;
            bit_cnt   <= bit_cnt + 5'd1;
            shift_reg <= {shift_reg[14:0], 1'b0};
            dac_din   <= shift_reg[14];
          end
        end

        SHIFT_LO: begin
          if (phase_end) begin
            if (bit_cnt == 5'd16) begin
              state    <= HOLD;
              dac_cs_n <= 1'b1;
              dac_din  <= 1'b0;
            end else begin
              state    <= SHIFT_HI;
              dac_sclk <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (phase_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          dac_cs_n <= 1'b1;
          dac_sclk <= 1'b0;
          dac_din  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
